// File: rtl/fp_minmax_reduce_pkg.sv
// rtl/fp_minmax_reduce_pkg.sv - shared state encoding and default widths for fp_minmax_reduce
package fp_minmax_reduce_pkg;

    localparam int DEF_BITS  = 16;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/flpcomp.sv
// rtl/flpcomp.sv - combinational sign-magnitude maximum of two floating-point words
module flpcomp #(
    parameter int Bits = 16
) (
    input  logic [Bits-1:0] a,
    input  logic [Bits-1:0] b,
    output logic [Bits-1:0] y
);

    logic            sign_a;
    logic            sign_b;
    logic [Bits-2:0] mag_a;
    logic [Bits-2:0] mag_b;

    assign sign_a = a[Bits-1];
    assign sign_b = b[Bits-1];
    assign mag_a  = a[Bits-2:0];
    assign mag_b  = b[Bits-2:0];

    // Positive beats negative; among positives the bigger magnitude wins (tie keeps a);
    // among negatives the smaller magnitude wins (tie keeps b). NaN/Inf are plain bit patterns here.
    always_comb begin
        y = a;
        if (sign_a != sign_b) begin
            y = sign_a ? b : a;
        end else if (!sign_a) begin
            y = (mag_b > mag_a) ? b : a;
        end else begin
            y = (mag_a < mag_b) ? a : b;
        end
    end

endmodule

// File: rtl/fp_minmax_reduce.sv
// rtl/fp_minmax_reduce.sv - streaming min/max/count reduction over floating-point elements
module fp_minmax_reduce
    import fp_minmax_reduce_pkg::*;
#(
    parameter int Bits  = DEF_BITS,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Bits-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Bits-1:0]  out_max,
    output logic [Bits-1:0]  out_min,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [Bits-1:0]  max_q;
    logic [Bits-1:0]  min_q;
    logic [CNT_W-1:0] count_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             accept;
    logic             consume;
    logic [Bits-1:0]  max_nx;
    logic [Bits-1:0]  min_a_flip;
    logic [Bits-1:0]  min_b_flip;
    logic [Bits-1:0]  min_y_flip;
    logic [Bits-1:0]  min_nx;
    logic [CNT_W-1:0] count_inc;

    assign accept  = in_valid && in_ready_q;
    assign consume = out_valid_q && out_ready;

    // Maximum of running value and new element.
    flpcomp #(.Bits(Bits)) u_max (
        .a (max_q),
        .b (in_data),
        .y (max_nx)
    );

    // Minimum is the maximum of the sign-flipped operands, flipped back.
    assign min_a_flip = {~min_q[Bits-1],   min_q[Bits-2:0]};
    assign min_b_flip = {~in_data[Bits-1], in_data[Bits-2:0]};
    assign min_nx     = {~min_y_flip[Bits-1], min_y_flip[Bits-2:0]};

    flpcomp #(.Bits(Bits)) u_min (
        .a (min_a_flip),
        .b (min_b_flip),
        .y (min_y_flip)
    );

    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;

    // FSM with running registers; handshake flags are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            max_q       <= '0;
            min_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    if (accept) begin
                        max_q   <= in_data;
                        min_q   <= in_data;
                        count_q <= CNT_ONE;
                        if (in_last) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    if (accept) begin
                        max_q   <= max_nx;
                        min_q   <= min_nx;
                        count_q <= count_inc;
                        if (in_last) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Result registers stay as-is after consumption; the next stream overwrites them.
                    if (consume) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_max   = max_q;
    assign out_min   = min_q;
    assign out_count = count_q;

endmodule
